// File: rtl/mem_nibble_responder.sv
// Memory-side responder for the DMA descriptor/nibble protocol with a byte-wide storage array.
// Optional LEN_CHECK_EN: over-length descriptors are acknowledged with done+err instead of executing.
module mem_nibble_responder #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mode,
   input  logic        addr_in_valid,
   output logic        addr_in_enable,
   input  logic [31:0] addr_in,
   input  logic [31:0] len_in,
   input  logic        dma_to_mem_valid,
   output logic        dma_to_mem_enable,
   input  logic [3:0]  mem_in_socket,
   output logic        mem_to_dma_valid,
   input  logic        mem_to_dma_enable,
   output logic [3:0]  mem_out_socket,
   output logic        busy,
   output logic        done
`ifdef LEN_CHECK_EN
   ,
   output logic        err
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              phase_q, phase_d;
   logic [ADDR_W-1:0] ptr_q,   ptr_d;
   logic [31:0]       rem_q,   rem_d;
   logic [3:0]        lo_q,    lo_d;
   logic [7:0]        mem_q [DEPTH];

   logic accept, wr_hs, rd_hs, byte_hs, last_byte, len_zero, len_over;

   // Only the low pointer bits address the array.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_in[31:ADDR_W];

   assign accept    = (state_q == S_IDLE) && addr_in_valid;
   assign wr_hs     = (state_q == S_WR) && dma_to_mem_valid;
   assign rd_hs     = (state_q == S_RD) && mem_to_dma_enable;
   assign byte_hs   = (wr_hs || rd_hs) && phase_q;
   assign last_byte = byte_hs && (rem_q == 32'd1);
   assign len_zero  = (len_in == 32'd0);
`ifdef LEN_CHECK_EN
   assign len_over  = (len_in > 32'(DEPTH));
`else
   assign len_over  = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (len_zero || len_over) state_d = S_DONE;
               else if (mode)            state_d = S_WR;
               else                      state_d = S_RD;
            end
         end
         S_WR, S_RD: if (last_byte) state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Outputs: registered state only; enable is held low while reset is asserted.
   always_comb begin
      addr_in_enable    = 1'b0;
      dma_to_mem_enable = 1'b0;
      mem_to_dma_valid  = 1'b0;
      mem_out_socket    = 4'h0;
      busy              = 1'b0;
      done              = 1'b0;
      case (state_q)
         S_IDLE: addr_in_enable = resetn;
         S_WR: begin
            dma_to_mem_enable = 1'b1;
            busy              = 1'b1;
         end
         S_RD: begin
            mem_to_dma_valid = 1'b1;
            busy             = 1'b1;
            mem_out_socket   = phase_q ? mem_q[ptr_q][7:4] : mem_q[ptr_q][3:0];
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: pointer, byte count, nibble phase, held low nibble.
   always_comb begin
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      phase_d = phase_q;
      lo_d    = lo_q;
      if (accept) begin
         ptr_d   = addr_in[ADDR_W-1:0];
         rem_d   = len_in;
         phase_d = 1'b0;
      end else if (wr_hs || rd_hs) begin
         phase_d = ~phase_q;
         if (!phase_q && wr_hs) lo_d = mem_in_socket;
         if (phase_q) begin
            ptr_d = ptr_q + 1'b1;
            rem_d = rem_q - 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr_q   <= '0;
         rem_q   <= '0;
         phase_q <= 1'b0;
         lo_q    <= 4'h0;
      end else begin
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         phase_q <= phase_d;
         lo_q    <= lo_d;
      end
   end

   // Storage is deliberately not reset; a byte lands only once both nibbles are in.
   always_ff @(posedge clk) begin
      if (wr_hs && phase_q) mem_q[ptr_q] <= {mem_in_socket, lo_q};
   end

`ifdef LEN_CHECK_EN
   logic err_q, err_d;
   assign err_d = accept && !len_zero && len_over;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) err_q <= 1'b0;
      else         err_q <= err_d;
   end
   assign err = err_q;
`endif

endmodule

// File: tb/tb_mem_nibble_responder.sv
// Randomized directed bench for mem_nibble_responder against a byte-array reference model.
module tb_mem_nibble_responder;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        mode = 1'b0;
   logic        addr_in_valid = 1'b0;
   logic        addr_in_enable;
   logic [31:0] addr_in = '0;
   logic [31:0] len_in = '0;
   logic        dma_to_mem_valid = 1'b0;
   logic        dma_to_mem_enable;
   logic [3:0]  mem_in_socket = '0;
   logic        mem_to_dma_valid;
   logic        mem_to_dma_enable = 1'b0;
   logic [3:0]  mem_out_socket;
   logic        busy;
   logic        done;
`ifdef LEN_CHECK_EN
   logic        err;
`endif

   mem_nibble_responder dut (
      .clk               (clk),
      .resetn            (resetn),
      .mode              (mode),
      .addr_in_valid     (addr_in_valid),
      .addr_in_enable    (addr_in_enable),
      .addr_in           (addr_in),
      .len_in            (len_in),
      .dma_to_mem_valid  (dma_to_mem_valid),
      .dma_to_mem_enable (dma_to_mem_enable),
      .mem_in_socket     (mem_in_socket),
      .mem_to_dma_valid  (mem_to_dma_valid),
      .mem_to_dma_enable (mem_to_dma_enable),
      .mem_out_socket    (mem_out_socket),
      .busy              (busy),
      .done              (done)
`ifdef LEN_CHECK_EN
      ,
      .err               (err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [7:0] ref_mem [256];
   logic [7:0] wbuf [300];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a descriptor once the responder is idle (bounded wait).
   task automatic send_desc(input logic m, input logic [31:0] a, input logic [31:0] l);
      int t = 0;
      while (addr_in_enable !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("desc_ready", {31'd0, addr_in_enable}, 32'd1);
      mode = m; addr_in = a; len_in = l; addr_in_valid = 1'b1;
      @(negedge clk);
      addr_in_valid = 1'b0;
      addr_in = $urandom; len_in = $urandom; mode = 1'($urandom);
   endtask

   // Called at the first sample point after the final handshake.
   task automatic end_chk(input string tag);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
      chk({tag, "_idle"}, {31'd0, addr_in_enable}, 32'd1);
   endtask

   task automatic do_write(input logic [31:0] a, input int n);
      int p;
      p = int'(a[7:0]);
      send_desc(1'b1, a, n);
      for (int i = 0; i < n; i++) begin
         for (int h = 0; h < 2; h++) begin
            repeat ($urandom_range(0, 2)) begin
               mem_to_dma_enable = 1'($urandom);
               @(negedge clk);
            end
            mem_to_dma_enable = 1'b0;
            dma_to_mem_valid = 1'b1;
            mem_in_socket = (h == 1) ? wbuf[i][7:4] : wbuf[i][3:0];
            chk("wr_enable", {31'd0, dma_to_mem_enable}, 32'd1);
            chk("wr_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
            dma_to_mem_valid = 1'b0;
            mem_in_socket = 4'($urandom);
         end
         ref_mem[p] = wbuf[i];
         p = (p + 1) % 256;
      end
      end_chk("wr");
   endtask

   task automatic do_read(input logic [31:0] a, input int n);
      int p;
      logic [7:0] b;
      logic [3:0] e;
      p = int'(a[7:0]);
      send_desc(1'b0, a, n);
      for (int i = 0; i < n; i++) begin
         b = ref_mem[p];
         for (int h = 0; h < 2; h++) begin
            e = (h == 1) ? b[7:4] : b[3:0];
            repeat ($urandom_range(0, 2)) begin
               mem_to_dma_enable = 1'b0;
               dma_to_mem_valid = 1'($urandom);
               chk("rd_stall_valid", {31'd0, mem_to_dma_valid}, 32'd1);
               chk("rd_stall_nibble", {28'd0, mem_out_socket}, {28'd0, e});
               @(negedge clk);
            end
            dma_to_mem_valid = 1'b0;
            mem_to_dma_enable = 1'b1;
            chk("rd_valid", {31'd0, mem_to_dma_valid}, 32'd1);
            chk("rd_nibble", {28'd0, mem_out_socket}, {28'd0, e});
            @(negedge clk);
            mem_to_dma_enable = 1'b0;
         end
         p = (p + 1) % 256;
      end
      end_chk("rd");
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_addr_en", {31'd0, addr_in_enable}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", {31'd0, addr_in_enable}, 32'd1);

      // Fill the whole array so every later read has a defined model value
      for (int i = 0; i < 256; i++) wbuf[i] = 8'($urandom);
      do_write(32'h0, 256);

      // Directed write: nibbles 5,A,3,C at 0x10
      wbuf[0] = 8'hA5; wbuf[1] = 8'hC3;
      do_write(32'h10, 2);
      do_read(32'h10, 2);

      // Directed read of a preloaded byte with random stalls
      wbuf[0] = 8'h7E;
      do_write(32'h20, 1);
      do_read(32'h20, 1);

      // Zero length: straight to done, no data side activity
      send_desc(1'($urandom), 32'h40, 32'd0);
      chk("zl_wr_en", {31'd0, dma_to_mem_enable}, 32'd0);
      chk("zl_rd_valid", {31'd0, mem_to_dma_valid}, 32'd0);
      end_chk("zl");

      // Wrap: upper address bits ignored, 0xFF then 0x00
      wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
      do_write(32'h1FF, 2);
      do_read(32'h0FF, 2);
      do_read(32'h300, 1);

      // Reset mid-write after one nibble: byte untouched, partial nibble dropped
      wbuf[0] = 8'h5A;
      do_write(32'h30, 1);
      send_desc(1'b1, 32'h30, 32'd1);
      dma_to_mem_valid = 1'b1; mem_in_socket = 4'hF;
      @(negedge clk);
      dma_to_mem_valid = 1'b1; mem_in_socket = 4'h1;
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_addr_en", {31'd0, addr_in_enable}, 32'd0);
      chk("mid_rst_wr_en", {31'd0, dma_to_mem_enable}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      dma_to_mem_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("mid_rst_idle", {31'd0, addr_in_enable}, 32'd1);
      @(negedge clk);
      do_read(32'h30, 1);

      // Over-length descriptor
`ifdef LEN_CHECK_EN
      send_desc(1'b1, 32'h50, 32'd257);
      chk("ovl_done", {31'd0, done}, 32'd1);
      chk("ovl_err", {31'd0, err}, 32'd1);
      chk("ovl_wr_en", {31'd0, dma_to_mem_enable}, 32'd0);
      @(negedge clk);
      chk("ovl_err_1cyc", {31'd0, err}, 32'd0);
      do_read(32'h50, 4);
`else
      for (int i = 0; i < 257; i++) wbuf[i] = 8'($urandom);
      do_write(32'h50, 257);
      do_read(32'h50, 256);
`endif

      // Random transfers
      for (int k = 0; k < 12; k++) begin
         int n;
         logic [31:0] a;
         n = $urandom_range(1, 8);
         a = $urandom;
         for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
         do_write(a, n);
         do_read(a, n);
         do_read($urandom, $urandom_range(1, 6));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
